// File: rtl/mul_if.sv
// Handshake and datapath bundle between decode, mul_sequencer and the HI/LO multiply unit.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface mul_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [2:0]           req_op;
    logic [BUS_WIDTH-1:0] req_in1;
    logic [BUS_WIDTH-1:0] req_in2;
    logic [4:0]           req_dest;
    logic                 flush;
    logic [BUS_WIDTH-1:0] unit_in1;
    logic [BUS_WIDTH-1:0] unit_in2;
    logic [2:0]           unit_mul_op;
    logic [BUS_WIDTH-1:0] unit_out;
    logic                 busy;
    logic                 mul_done;
    logic                 wb_valid;
    logic [4:0]           wb_dest;
    logic [BUS_WIDTH-1:0] wb_data;

    modport slave (
        input  req_valid, req_op, req_in1, req_in2, req_dest, flush, unit_out,
        output req_ready, unit_in1, unit_in2, unit_mul_op, busy, mul_done,
               wb_valid, wb_dest, wb_data
    );

    modport master (
        output req_valid, req_op, req_in1, req_in2, req_dest, flush, unit_out,
        input  req_ready, unit_in1, unit_in2, unit_mul_op, busy, mul_done,
               wb_valid, wb_dest, wb_data
    );
endinterface

// File: rtl/mul_sequencer.sv
// Issue controller for the HI/LO multiply unit: holds operands for MUL_LATENCY cycles,
// commits the multiply op for exactly one cycle, and sequences MFHI/MFLO writebacks.
module mul_sequencer #(
    parameter int         BUS_WIDTH   = 32,
    parameter int         MUL_LATENCY = 3,
    parameter logic [2:0] MADD        = 3'b000,
    parameter logic [2:0] MADDU       = 3'b001,
    parameter logic [2:0] MUL         = 3'b010,
    parameter logic [2:0] MFLO        = 3'b100,
    parameter logic [2:0] MFHI        = 3'b101,
    parameter logic [2:0] NOP         = 3'b111
) (
    input logic  clk,
    input logic  rst,
    mul_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, COMMIT, READ} state_t;

    localparam logic [3:0] CNT_INIT = (MUL_LATENCY > 1) ? 4'(MUL_LATENCY - 2) : 4'd0;

    state_t               state, state_nxt;
    logic [2:0]           op_q;
    logic [BUS_WIDTH-1:0] in1_q, in2_q;
    logic [4:0]           dest_q;
    logic [3:0]           cnt_q;
    logic                 accept;
    logic                 req_is_mul, req_is_mf;

    assign accept     = bus.req_valid && bus.req_ready;
    assign req_is_mul = (bus.req_op == MADD) || (bus.req_op == MADDU) || (bus.req_op == MUL);
    assign req_is_mf  = (bus.req_op == MFLO) || (bus.req_op == MFHI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_is_mul)     state_nxt = (MUL_LATENCY > 1) ? EXEC : COMMIT;
                    else if (req_is_mf) state_nxt = READ;
                    else                state_nxt = IDLE;
                end
            end
            EXEC: begin
                if (bus.flush)        state_nxt = IDLE;
                else if (cnt_q == '0) state_nxt = COMMIT;
            end
            COMMIT:  state_nxt = IDLE;
            READ:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Commit is gated by flush combinationally so an aborted multiply never reaches HI/LO.
    always_comb begin
        bus.req_ready   = (state == IDLE) && !bus.flush;
        bus.busy        = (state != IDLE);
        bus.mul_done    = 1'b0;
        bus.unit_mul_op = NOP;
        case (state)
            COMMIT: begin
                if (!bus.flush) begin
                    bus.unit_mul_op = op_q;
                    bus.mul_done    = 1'b1;
                end
            end
            READ:    bus.unit_mul_op = op_q;
            default: bus.unit_mul_op = NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= NOP;
            in1_q  <= '0;
            in2_q  <= '0;
            dest_q <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            op_q   <= bus.req_op;
            in1_q  <= bus.req_in1;
            in2_q  <= bus.req_in2;
            dest_q <= bus.req_dest;
            cnt_q  <= CNT_INIT;
        end else if (state == EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign bus.unit_in1 = in1_q;
    assign bus.unit_in2 = in2_q;

    // Writeback stage: capture the unit's read port at the end of READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_valid <= 1'b0;
            bus.wb_dest  <= '0;
            bus.wb_data  <= '0;
        end else begin
            bus.wb_valid <= (state == READ) && !bus.flush;
            if (state == READ && !bus.flush) begin
                bus.wb_dest <= dest_q;
                bus.wb_data <= bus.unit_out;
            end
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural HI/LO multiply unit attached.
module tb_mul_sequencer;
    localparam int         LAT   = 3;
    localparam logic [2:0] MADD  = 3'b000;
    localparam logic [2:0] MADDU = 3'b001;
    localparam logic [2:0] MUL   = 3'b010;
    localparam logic [2:0] MFLO  = 3'b100;
    localparam logic [2:0] MFHI  = 3'b101;
    localparam logic [2:0] NOP   = 3'b111;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   mulop_cnt = 0;
    int   acc_cnt = 0;

    mul_if #(.BUS_WIDTH(32)) bus ();

    mul_sequencer #(.BUS_WIDTH(32), .MUL_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural multiply unit: HI/LO updated on the clock edge per mul_op.
    logic [63:0] hilo = 64'd0;
    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{bus.unit_in1[31]}}, bus.unit_in1} * {{32{bus.unit_in2[31]}}, bus.unit_in2};
    assign prod_u = {32'd0, bus.unit_in1} * {32'd0, bus.unit_in2};
    always @(posedge clk) begin
        case (bus.unit_mul_op)
            MUL:     hilo <= prod_s;
            MADD:    hilo <= hilo + prod_s;
            MADDU:   hilo <= hilo + prod_u;
            default: ;
        endcase
    end
    assign bus.unit_out = (bus.unit_mul_op == MFHI) ? hilo[63:32] : hilo[31:0];

    always @(posedge clk) begin
        if (bus.mul_done)                    done_cnt  <= done_cnt + 1;
        if (bus.unit_mul_op == MUL)          mulop_cnt <= mulop_cnt + 1;
        if (bus.req_valid && bus.req_ready)  acc_cnt   <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int lat;
        int d0;
        lat = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_in1 = a; bus.req_in2 = b;
        #1 check({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        d0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (k == 1) check({tag, "_in1"}, bus.unit_in1, a);
            if (bus.mul_done && lat == 0) begin
                lat = k;
                check({tag, "_op"}, 32'(bus.unit_mul_op), 32'(op));
            end
            if (!bus.busy) break;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic do_mf(input logic [2:0] op, input logic [4:0] dest, input logic [31:0] exp,
                         input string tag);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_dest = dest;
        #1 check({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 check({tag, "_rdop"}, 32'(bus.unit_mul_op), 32'(op));
        check({tag, "_wbv0"}, 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        #1 check({tag, "_wbv"}, 32'(bus.wb_valid), 32'd1);
        check({tag, "_data"}, bus.wb_data, exp);
        check({tag, "_dest"}, 32'(bus.wb_dest), 32'(dest));
        @(negedge clk);
        #1 check({tag, "_wbv_off"}, 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int a0;
        int m0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = NOP; bus.req_in1 = '0; bus.req_in2 = '0;
        bus.req_dest = '0; bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.mul_done), 32'd0);
        check("rst_wbv", 32'(bus.wb_valid), 32'd0);
        check("rst_op", 32'(bus.unit_mul_op), 32'(NOP));
        check("rst_in1", bus.unit_in1, 32'd0);
        check("rst_wbdata", bus.wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // MUL 3 x -2 -> HI/LO = 0xFFFFFFFF_FFFFFFFA
        m0 = mulop_cnt;
        do_mul(MUL, 32'd3, 32'hFFFF_FFFE, "t1_mul");
        check("t1_mulop_cycles", 32'(mulop_cnt - m0), 32'd1);
        do_mf(MFHI, 5'd3, 32'hFFFF_FFFF, "t1_mfhi");
        do_mf(MFLO, 5'd4, 32'hFFFF_FFFA, "t1_mflo");

        // MUL 2x3 then MADD 4x5 -> 26
        do_mul(MUL, 32'd2, 32'd3, "t2_mul");
        do_mul(MADD, 32'd4, 32'd5, "t2_madd");
        do_mf(MFLO, 5'd5, 32'd26, "t2_mflo");
        do_mf(MFHI, 5'd6, 32'd0, "t2_mfhi");

        // MUL 0x0 then MADDU 0xFFFFFFFF x 2 -> 0x1_FFFFFFFE
        do_mul(MUL, 32'd0, 32'd0, "t3_mul");
        do_mul(MADDU, 32'hFFFF_FFFF, 32'd2, "t3_maddu");
        do_mf(MFHI, 5'd7, 32'd1, "t3_mfhi");
        do_mf(MFLO, 5'd8, 32'hFFFF_FFFE, "t3_mflo");

        // MUL 5x5, MADD 7x7 flushed in its second EXEC cycle
        do_mul(MUL, 32'd5, 32'd5, "t4_mul");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MADD; bus.req_in1 = 32'd7; bus.req_in2 = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        d0 = done_cnt;
        @(negedge clk);
        bus.flush = 1'b1;
        #1 check("t4_flush_op", 32'(bus.unit_mul_op), 32'(NOP));
        check("t4_flush_done", 32'(bus.mul_done), 32'd0);
        check("t4_flush_rdy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1 check("t4_rdy_after", 32'(bus.req_ready), 32'd1);
        check("t4_busy_after", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_done", 32'(done_cnt - d0), 32'd0);
        do_mf(MFLO, 5'd9, 32'd25, "t4_mflo");

        // MUL 1x1, reset in the middle of MADD 9x9
        do_mul(MUL, 32'd1, 32'd1, "t5_mul");
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MADD; bus.req_in1 = 32'd9; bus.req_in2 = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        d0 = done_cnt;
        rst = 1'b1;
        #1 check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_op", 32'(bus.unit_mul_op), 32'(NOP));
        check("t5_rst_in1", bus.unit_in1, 32'd0);
        check("t5_rst_wbdata", bus.wb_data, 32'd0);
        check("t5_rst_wbdest", 32'(bus.wb_dest), 32'd0);
        check("t5_rst_wbv", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        do_mf(MFLO, 5'd10, 32'd1, "t5_mflo");

        // Back-to-back MFLO, MUL, MFHI with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MFLO; bus.req_dest = 5'd7;
        a0 = acc_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_op = MUL; bus.req_in1 = 32'h10; bus.req_in2 = 32'h20;
        #1 check("t6_rdy_read", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #1 check("t6_wbv", 32'(bus.wb_valid), 32'd1);
        check("t6_wbdata", bus.wb_data, 32'd1);
        check("t6_wbdest", 32'(bus.wb_dest), 32'd7);
        check("t6_rdy_wb", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_op = MFHI; bus.req_dest = 5'd9; bus.req_in1 = 32'h55;
        #1 check("t6_wbv_off", 32'(bus.wb_valid), 32'd0);
        check("t6_hold1", bus.unit_in1, 32'h10);
        @(negedge clk);
        bus.req_in1 = 32'hAA;
        #1 check("t6_hold2", bus.unit_in1, 32'h10);
        @(negedge clk);
        #1 check("t6_done", 32'(bus.mul_done), 32'd1);
        check("t6_commit_op", 32'(bus.unit_mul_op), 32'(MUL));
        @(negedge clk);
        #1 check("t6_rdy_idle", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 check("t6_mfhi_op", 32'(bus.unit_mul_op), 32'(MFHI));
        @(negedge clk);
        #1 check("t6_mfhi_wbv", 32'(bus.wb_valid), 32'd1);
        check("t6_mfhi_data", bus.wb_data, 32'd0);
        check("t6_mfhi_dest", 32'(bus.wb_dest), 32'd9);
        check("t6_accepts", 32'(acc_cnt - a0), 32'd3);
        do_mf(MFLO, 5'd11, 32'h200, "t6_mflo");

        // Undefined op is accepted and dropped; flush in IDLE blocks accept
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 3'b110;
        a0 = acc_cnt;
        #1 check("t7_rdy", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1 check("t7_busy", 32'(bus.busy), 32'd0);
        check("t7_op", 32'(bus.unit_mul_op), 32'(NOP));
        check("t7_wbv", 32'(bus.wb_valid), 32'd0);
        check("t7_accepts", 32'(acc_cnt - a0), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = MUL; bus.flush = 1'b1;
        #1 check("t7_flush_rdy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0; bus.flush = 1'b0;
        #1 check("t7_flush_busy", 32'(bus.busy), 32'd0);
        do_mf(MFLO, 5'd12, 32'h200, "t7_mflo");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Issue controller placed between decode and multiply_unit (HI/LO multiply-accumulate datapath).
- Accepts one multiply-class request at a time over a valid/ready handshake.
- Holds operands stable to the unit for MUL_LATENCY cycles, then asserts the real mul_op for exactly one commit cycle, so HI/LO is written once per MUL/MADD/MADDU.
- Sequences MFHI/MFLO reads and returns a registered writeback.

Parameters:
- BUS_WIDTH, 32, operand/result width.
- MUL_LATENCY, 3, cycles operands are held before commit, including the commit cycle; legal range 1..15.
- MADD, 3'b000; MADDU, 3'b001; MUL, 3'b010; MFLO, 3'b100; MFHI, 3'b101: operation codes shared with the multiply unit.
- NOP, 3'b111, code driven when idle; causes no HI/LO write.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_op  in  3  operation code.
- req_in1  in  BUS_WIDTH  operand 1.
- req_in2  in  BUS_WIDTH  operand 2.
- req_dest  in  5  destination register for MFHI/MFLO.
- flush  in  1  abort any in-flight multiply without commit.
- unit_in1  out  BUS_WIDTH  to multiply_unit in1.
- unit_in2  out  BUS_WIDTH  to multiply_unit in2.
- unit_mul_op  out  3  to multiply_unit mul_op.
- unit_out  in  BUS_WIDTH  from multiply_unit out.
- busy  out  1  operation in flight.
- mul_done  out  1  one-cycle pulse: HI/LO updated at the end of this cycle.
- wb_valid  out  1  one-cycle pulse: MF* result valid.
- wb_dest  out  5  writeback register.
- wb_data  out  BUS_WIDTH  writeback value.

Behaviour:
- States: IDLE, EXEC, COMMIT, READ.
- Accept occurs when req_valid and req_ready are both high at a clk edge.
- req_ready equals state==IDLE and flush low.
- Reset (async, any state): state IDLE, unit_mul_op=NOP, operand registers 0, counter 0, busy 0, mul_done 0, wb_valid 0, wb_dest 0, wb_data 0. Reset mid-operation never produces a HI/LO write.
- On accept, latch req_op, req_in1, req_in2, req_dest into registers. unit_in1/unit_in2 come from those registers and are stable until the next accept.
- MUL/MADD/MADDU accept:
  - MUL_LATENCY>1: go to EXEC, counter=MUL_LATENCY-2. MUL_LATENCY=1: go straight to COMMIT.
  - EXEC: unit_mul_op=NOP. Decrement the counter each cycle; move to COMMIT when it reaches 0.
  - COMMIT: unit_mul_op=latched op and mul_done=1 (both combinational from state) for exactly one cycle, then IDLE.
  - Operands are therefore applied MUL_LATENCY cycles before the HI/LO capture edge. in1/in2 to HI/LO is a multicycle path of MUL_LATENCY; mul_op is single-cycle.
- MFHI/MFLO accept:
  - Go to READ (one cycle). unit_mul_op=latched op.
  - At the end of READ, register wb_data<=unit_out and wb_dest<=latched dest, set wb_valid=1, go to IDLE.
  - wb_valid lasts exactly one cycle, which is also the first cycle req_ready is high again. A new request may be accepted in that cycle.
- Hazard: single outstanding operation. An MF* accepted after a multiply always reads the committed HI/LO.
- flush:
  - In EXEC or COMMIT: go to IDLE next edge; unit_mul_op is forced to NOP in that cycle (combinational), so no commit and no mul_done.
  - In READ: suppress wb_valid.
  - In IDLE: block accept that cycle.
- Undefined req_op (011, 110, 111): accepted and dropped. Stays IDLE; no output activity.
- busy = state!=IDLE.
- Changes on req_* while not accepting are ignored.

Test Plan:
- MUL 3 x 0xFFFFFFFE (-2), MUL_LATENCY=3, then MFHI, then MFLO -> mul_done exactly 3 cycles after accept; wb_data 0xFFFFFFFF then 0xFFFFFFFA; unit_mul_op=MUL in exactly one cycle.
- MUL 2x3, then MADD 4x5, then MFLO -> wb_data=26 (not 46), proving a single accumulation; MFHI -> 0.
- MUL 0x0x0, then MADDU 0xFFFFFFFF x 2, then MFHI/MFLO -> 0x00000001 / 0xFFFFFFFE.
- MUL 5x5, then MADD 7x7 with flush asserted in the second EXEC cycle, then MFLO -> 25; no mul_done for the MADD; req_ready high the next cycle.
- rst pulsed mid-EXEC of MADD after MUL 1x1, then MFLO -> wb_data=1 (HI/LO untouched by the aborted op); all outputs at reset values during rst.
- req_valid held high with ops MFLO, MUL, MFHI back-to-back; req_in1 toggled during EXEC -> one accept per IDLE cycle, wb_valid coincides with the next accept, result uses the latched operands.
